// File: rtl/bbus_seq_if.sv
// bbus_seq_if: requester handshakes and shared byte-bus pins of the W5300/SL811 sequencer
interface bbus_seq_if;
    logic       w_req;
    logic       w_rnw;
    logic [9:0] w_addr;
    logic [7:0] w_wdata;
    logic       w_ack;
    logic [7:0] w_rdata;
    logic       s_req;
    logic       s_rnw;
    logic       s_a0;
    logic [7:0] s_wdata;
    logic       s_ack;
    logic [7:0] s_rdata;
    logic [7:0] bd_i;
    logic [7:0] bd_o;
    logic       bd_oe;
    logic       brd_n;
    logic       bwr_n;
    logic [9:0] w5300_addr;
    logic       w5300_cs_n;
    logic       sl811_a0;
    logic       sl811_cs_n;
    logic       busy;
    modport slave (
        input  w_req, w_rnw, w_addr, w_wdata, s_req, s_rnw, s_a0, s_wdata, bd_i,
        output w_ack, w_rdata, s_ack, s_rdata, bd_o, bd_oe, brd_n, bwr_n,
               w5300_addr, w5300_cs_n, sl811_a0, sl811_cs_n, busy
    );
    modport master (
        output w_req, w_rnw, w_addr, w_wdata, s_req, s_rnw, s_a0, s_wdata, bd_i,
        input  w_ack, w_rdata, s_ack, s_rdata, bd_o, bd_oe, brd_n, bwr_n,
               w5300_addr, w5300_cs_n, sl811_a0, sl811_cs_n, busy
    );
endinterface

// File: rtl/bbus_seq.sv
// bbus_seq: round-robin arbiter and timed access sequencer for the shared W5300/SL811 byte bus
module bbus_seq #(
    parameter int SETUP_W = 1,
    parameter int STB_W   = 2,
    parameter int STB_S   = 3,
    parameter int RECOV   = 2,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    bbus_seq_if.slave  b
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STB, S_HOLD, S_RECOV} state_t;
    localparam logic [CNT_W-1:0] SETUP_L = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] STBW_L  = CNT_W'(STB_W - 1);
    localparam logic [CNT_W-1:0] STBS_L  = CNT_W'(STB_S - 1);
    localparam logic [CNT_W-1:0] RECOV_L = CNT_W'(RECOV > 0 ? RECOV - 1 : 0);
    state_t           st, nxt;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             gnt_s, rnw, pri_s, a0_q;
    logic [9:0]       addr_q;
    logic [7:0]       wd_q, wr_q, sr_q;
    logic             req, win_s, last, act, stb;
    assign req   = b.w_req | b.s_req;
    // pri_s points away from the last winner, so simultaneous requests alternate
    assign win_s = b.s_req & (~b.w_req | pri_s);
    assign last  = cnt == '0;
    always_comb begin
        nxt   = st;
        cnt_d = last ? cnt : cnt - 1'b1;
        case (st)
            S_IDLE: begin
                nxt   = req ? S_SETUP : S_IDLE;
                cnt_d = SETUP_L;
            end
            S_SETUP: if (last) begin
                nxt   = S_STB;
                cnt_d = gnt_s ? STBS_L : STBW_L;
            end
            S_STB:   nxt = last ? S_HOLD : S_STB;
            S_HOLD: begin
                nxt   = RECOV == 0 ? S_IDLE : S_RECOV;
                cnt_d = RECOV_L;
            end
            S_RECOV: nxt = last ? S_IDLE : S_RECOV;
            default: nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st  <= S_IDLE;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= cnt_d;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            gnt_s  <= 1'b0;
            rnw    <= 1'b0;
            pri_s  <= 1'b0;
            a0_q   <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
            wr_q   <= '0;
            sr_q   <= '0;
        end else begin
            if (st == S_IDLE && req) begin
                gnt_s <= win_s;
                pri_s <= ~win_s;
                rnw   <= win_s ? b.s_rnw : b.w_rnw;
                wd_q  <= win_s ? b.s_wdata : b.w_wdata;
                if (win_s) a0_q <= b.s_a0;
                else addr_q <= b.w_addr;
            end
            if (st == S_STB && last && rnw) begin
                if (gnt_s) sr_q <= b.bd_i;
                else wr_q <= b.bd_i;
            end
        end
    // bus pins decode straight from state so an async reset releases them at once
    assign act          = st inside {S_SETUP, S_STB, S_HOLD};
    assign stb          = st == S_STB;
    assign b.w5300_cs_n = ~(act & ~gnt_s);
    assign b.sl811_cs_n = ~(act & gnt_s);
    assign b.brd_n      = ~(stb & rnw);
    assign b.bwr_n      = ~(stb & ~rnw);
    assign b.bd_oe      = act & ~rnw;
    assign b.bd_o       = wd_q;
    assign b.w5300_addr = addr_q;
    assign b.sl811_a0   = a0_q;
    assign b.w_ack      = (st == S_HOLD) & ~gnt_s;
    assign b.s_ack      = (st == S_HOLD) & gnt_s;
    assign b.w_rdata    = wr_q;
    assign b.s_rdata    = sr_q;
    assign b.busy       = st != S_IDLE;
endmodule

// File: tb/tb_bbus_seq.sv
// tb_bbus_seq: directed scenarios plus randomized traffic checked against a timeline model
module tb_bbus_seq;
    localparam int SW = 1, TW = 2, TS = 3, RC = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    bbus_seq_if b ();
    bbus_seq_if b1 ();
    bbus_seq #(.SETUP_W(SW), .STB_W(TW), .STB_S(TS), .RECOV(RC), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .b(b.slave));
    bbus_seq #(.SETUP_W(SW), .STB_W(TW), .STB_S(TS), .RECOV(0), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .b(b1.slave));

    // Model: each access is a window of cycles relative to its grant cycle t0
    int cyc, t0, len, free_at, rel;
    logic have, m_gs, m_rnw, m_pri, m_ws, m_a0;
    logic [9:0] m_addr;
    logic [7:0] m_wd, m_wr, m_sr;
    logic e_act, e_stb, e_busy, e_wack, e_sack;
    logic [5:0] e_ctl;
    assign m_ws   = b.s_req && (!b.w_req || m_pri);
    assign rel    = cyc - t0;
    assign e_act  = have && rel >= 1 && rel <= len;
    assign e_stb  = have && rel >= SW + 1 && rel <= len - 1;
    assign e_busy = have && rel >= 1 && rel <= len + RC;
    assign e_wack = have && rel == len && !m_gs;
    assign e_sack = have && rel == len && m_gs;
    assign e_ctl  = {~(e_act & ~m_gs), ~(e_act & m_gs), ~(e_stb & m_rnw), ~(e_stb & ~m_rnw),
                     e_act & ~m_rnw, e_busy};
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cyc <= 0; t0 <= 0; len <= 0; free_at <= 0; have <= 1'b0;
            m_gs <= 1'b0; m_rnw <= 1'b0; m_pri <= 1'b0; m_a0 <= 1'b0;
            m_addr <= '0; m_wd <= '0; m_wr <= '0; m_sr <= '0;
        end else begin
            cyc <= cyc + 1;
            if (cyc >= free_at && (b.w_req || b.s_req)) begin
                have    <= 1'b1;
                t0      <= cyc;
                m_gs    <= m_ws;
                m_pri   <= !m_ws;
                len     <= SW + (m_ws ? TS : TW) + 1;
                free_at <= cyc + SW + (m_ws ? TS : TW) + 2 + RC;
                m_rnw   <= m_ws ? b.s_rnw : b.w_rnw;
                m_wd    <= m_ws ? b.s_wdata : b.w_wdata;
                if (m_ws) m_a0 <= b.s_a0;
                else m_addr <= b.w_addr;
            end
            if (have && m_rnw && rel == len - 1) begin
                if (m_gs) m_sr <= b.bd_i;
                else m_wr <= b.bd_i;
            end
        end

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int i = 0;
        while ((b.busy || cyc < free_at) && i < 30) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (b.busy !== 1'b0) begin errors++; $display("FAIL idle_wait busy=%b exp 0", b.busy); end
    endtask

    task automatic test_reset();
        {b.w_req, b.w_rnw, b.w_addr, b.w_wdata, b.s_req, b.s_rnw, b.s_a0, b.s_wdata, b.bd_i} = '0;
        {b1.w_req, b1.w_rnw, b1.w_addr, b1.w_wdata, b1.s_req, b1.s_rnw, b1.s_a0, b1.s_wdata, b1.bd_i} = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b.w5300_cs_n, b.sl811_cs_n, b.brd_n, b.bwr_n, b.bd_oe, b.busy, b.w_ack, b.s_ack} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 11110000",
                     {b.w5300_cs_n, b.sl811_cs_n, b.brd_n, b.bwr_n, b.bd_oe, b.busy, b.w_ack, b.s_ack});
        end
        checks++;
        if ({b.bd_o, b.w_rdata, b.s_rdata, b.w5300_addr, b.sl811_a0} !== 35'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {b.bd_o, b.w_rdata, b.s_rdata, b.w5300_addr, b.sl811_a0});
        end
        checks++;
        if ({b1.w5300_cs_n, b1.sl811_cs_n, b1.brd_n, b1.bwr_n, b1.bd_oe, b1.busy} !== 6'b111100) begin
            errors++;
            $display("FAIL reset_dut1 got %b exp 111100",
                     {b1.w5300_cs_n, b1.sl811_cs_n, b1.brd_n, b1.bwr_n, b1.bd_oe, b1.busy});
        end
    endtask

    task automatic test_w_write();
        int cs_cnt = 0, ack_at = -1;
        logic [7:0] wr_mask = '0;
        bit s_low = 0, bad = 0;
        b.w_req = 1; b.w_rnw = 0; b.w_addr = 10'h2AB; b.w_wdata = 8'h5A;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (!b.w5300_cs_n) begin
                cs_cnt++;
                if (b.bd_o !== 8'h5A || b.bd_oe !== 1'b1 || b.w5300_addr !== 10'h2AB) bad = 1;
            end
            if (!b.bwr_n) wr_mask[i] = 1'b1;
            if (!b.sl811_cs_n) s_low = 1;
            if (b.w_ack) begin ack_at = i; b.w_req = 0; end
        end
        b.w_req = 0;
        checks++; if (cs_cnt !== 4) begin errors++; $display("FAIL wwr_cs_len got %0d exp 4", cs_cnt); end
        checks++; if (wr_mask !== 8'b0000_1100) begin errors++; $display("FAIL wwr_bwr_mask got %b exp 00001100", wr_mask); end
        checks++; if (ack_at !== 4) begin errors++; $display("FAIL wwr_ack_cycle got %0d exp 4", ack_at); end
        checks++; if (s_low !== 1'b0) begin errors++; $display("FAIL wwr_sl_cs got %b exp 0", s_low); end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL wwr_bus_data got %b exp 0", bad); end
        wait_idle();
    endtask

    task automatic test_s_read();
        int rd_cnt = 0, ack_at = -1;
        logic [7:0] rd = '0;
        bit bad_a0 = 0, oe = 0;
        @(negedge clk);
        b.bd_i = 8'hC3; b.s_req = 1; b.s_rnw = 1; b.s_a0 = 1; b.s_wdata = 8'($urandom);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (!b.brd_n) rd_cnt++;
            if (b.bd_oe || !b.bwr_n) oe = 1;
            if (!b.sl811_cs_n && b.sl811_a0 !== 1'b1) bad_a0 = 1;
            if (b.s_ack) begin ack_at = i; rd = b.s_rdata; b.s_req = 0; end
        end
        b.s_req = 0;
        checks++; if (rd_cnt !== 3) begin errors++; $display("FAIL srd_brd_len got %0d exp 3", rd_cnt); end
        checks++; if (rd !== 8'hC3) begin errors++; $display("FAIL srd_rdata got %h exp c3", rd); end
        checks++; if (ack_at !== 5) begin errors++; $display("FAIL srd_ack_cycle got %0d exp 5", ack_at); end
        checks++; if (bad_a0 !== 1'b0) begin errors++; $display("FAIL srd_a0 got %b exp 0", bad_a0); end
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL srd_oe got %b exp 0", oe); end
        wait_idle();
    endtask

    task automatic test_arb();
        int n = 0;
        int ack_cyc[4] = '{default: 0};
        bit ack_s[4] = '{default: 0};
        bit wr = 0, sr = 0;
        @(negedge clk);
        b.w_req = 1; b.s_req = 1; b.w_rnw = 0; b.s_rnw = 0;
        b.w_addr = 10'($urandom); b.w_wdata = 8'($urandom); b.s_wdata = 8'($urandom);
        for (int i = 1; i <= 80 && n < 4; i++) begin
            @(negedge clk);
            if (wr) begin b.w_req = 1; wr = 0; end
            if (sr) begin b.s_req = 1; sr = 0; end
            if (b.w_ack) begin ack_cyc[n] = i; ack_s[n] = 0; n++; b.w_req = 0; wr = n < 4; end
            else if (b.s_ack) begin ack_cyc[n] = i; ack_s[n] = 1; n++; b.s_req = 0; sr = n < 4; end
        end
        b.w_req = 0; b.s_req = 0;
        checks++; if (n !== 4) begin errors++; $display("FAIL arb_count got %0d exp 4", n); end
        checks++; if (ack_cyc[0] !== SW + TW + 1) begin errors++; $display("FAIL arb_first_ack got %0d exp %0d", ack_cyc[0], SW + TW + 1); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (ack_s[k] !== 1'(k % 2)) begin errors++; $display("FAIL arb_order k=%0d got %0d exp %0d", k, ack_s[k], k % 2); end
            if (k > 0) begin
                checks++;
                if (ack_cyc[k] - ack_cyc[k-1] !== RC + 1 + SW + (k % 2 == 1 ? TS : TW) + 1) begin
                    errors++;
                    $display("FAIL arb_spacing k=%0d got %0d exp %0d", k, ack_cyc[k] - ack_cyc[k-1],
                             RC + 1 + SW + (k % 2 == 1 ? TS : TW) + 1);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit acked = 0, busy_seen = 0;
        @(negedge clk);
        b.w_req = 1; b.w_rnw = 1; b.w_addr = 10'($urandom);
        repeat (2) @(negedge clk);
        checks++; if (b.brd_n !== 1'b0) begin errors++; $display("FAIL rstmid_strobe got %b exp 0", b.brd_n); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({b.brd_n, b.bwr_n, b.w5300_cs_n, b.sl811_cs_n, b.busy} !== 5'b11110) begin
            errors++;
            $display("FAIL rstmid_async got %b exp 11110", {b.brd_n, b.bwr_n, b.w5300_cs_n, b.sl811_cs_n, b.busy});
        end
        b.w_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b.w_ack || b.s_ack) acked = 1;
            if (b.busy) busy_seen = 1;
        end
        checks++; if (acked !== 1'b0) begin errors++; $display("FAIL rstmid_ack got %b exp 0", acked); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy_seen); end
    endtask

    task automatic test_drop_setup();
        int acks = 0, cs_cnt = 0;
        @(negedge clk);
        b.s_req = 1; b.s_rnw = 0; b.s_a0 = 0; b.s_wdata = 8'($urandom);
        @(negedge clk);
        b.s_req = 0;
        if (!b.sl811_cs_n) cs_cnt++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!b.sl811_cs_n) cs_cnt++;
            if (b.s_ack) acks++;
        end
        checks++; if (acks !== 1) begin errors++; $display("FAIL drop_acks got %0d exp 1", acks); end
        checks++; if (cs_cnt !== SW + TS + 1) begin errors++; $display("FAIL drop_cs_len got %0d exp %0d", cs_cnt, SW + TS + 1); end
        checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b exp 0", b.busy); end
    endtask

    task automatic test_back_to_back();
        int n = 0, cs_hi = 0;
        int ack_cyc[3] = '{default: 0};
        bit ovl = 0;
        @(negedge clk);
        b1.w_req = 1; b1.w_rnw = 0; b1.w_addr = 10'h155; b1.w_wdata = 8'hA5;
        for (int i = 1; i <= 40 && n < 3; i++) begin
            @(negedge clk);
            if (!b1.brd_n && !b1.bwr_n) ovl = 1;
            if (n > 0 && b1.w5300_cs_n) cs_hi++;
            if (b1.w_ack) begin ack_cyc[n] = i; n++; b1.w_rnw = ~b1.w_rnw; end
        end
        b1.w_req = 0;
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", n); end
        checks++; if (ack_cyc[0] !== SW + TW + 1) begin errors++; $display("FAIL b2b_first_ack got %0d exp %0d", ack_cyc[0], SW + TW + 1); end
        checks++; if (ack_cyc[1] - ack_cyc[0] !== SW + TW + 2) begin errors++; $display("FAIL b2b_spacing1 got %0d exp %0d", ack_cyc[1] - ack_cyc[0], SW + TW + 2); end
        checks++; if (ack_cyc[2] - ack_cyc[1] !== SW + TW + 2) begin errors++; $display("FAIL b2b_spacing2 got %0d exp %0d", ack_cyc[2] - ack_cyc[1], SW + TW + 2); end
        checks++; if (cs_hi !== 2) begin errors++; $display("FAIL b2b_idle_gaps got %0d exp 2", cs_hi); end
        checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL b2b_overlap got %b exp 0", ovl); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        bit wp = 0, sp = 0;
        int wg = 0, sg = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            checks++;
            if ({b.w5300_cs_n, b.sl811_cs_n, b.brd_n, b.bwr_n, b.bd_oe, b.busy} !== e_ctl) begin
                errors++;
                $display("FAIL rand_ctl cyc=%0d got %b exp %b", cyc,
                         {b.w5300_cs_n, b.sl811_cs_n, b.brd_n, b.bwr_n, b.bd_oe, b.busy}, e_ctl);
            end
            checks++;
            if ({b.w_ack, b.s_ack} !== {e_wack, e_sack}) begin
                errors++; $display("FAIL rand_ack cyc=%0d got %b exp %b", cyc, {b.w_ack, b.s_ack}, {e_wack, e_sack});
            end
            checks++;
            if ({b.w5300_addr, b.sl811_a0, b.bd_o} !== {m_addr, m_a0, m_wd}) begin
                errors++; $display("FAIL rand_addr cyc=%0d got %h exp %h", cyc,
                                   {b.w5300_addr, b.sl811_a0, b.bd_o}, {m_addr, m_a0, m_wd});
            end
            checks++;
            if ({b.w_rdata, b.s_rdata} !== {m_wr, m_sr}) begin
                errors++; $display("FAIL rand_rdata cyc=%0d got %h exp %h", cyc, {b.w_rdata, b.s_rdata}, {m_wr, m_sr});
            end
            b.bd_i = 8'($urandom);
            if (e_wack) begin b.w_req = 0; wp = 0; wg = $urandom_range(0, 3); end
            else if (!wp) begin
                if (wg > 0) wg--;
                else if ($urandom_range(0, 1) == 1) begin
                    b.w_req = 1; wp = 1; b.w_rnw = 1'($urandom);
                    b.w_addr = 10'($urandom); b.w_wdata = 8'($urandom);
                end
            end else if (e_act && !m_gs) begin
                b.w_rnw = 1'($urandom); b.w_addr = 10'($urandom); b.w_wdata = 8'($urandom);
                if ($urandom_range(0, 7) == 0) b.w_req = 0;
            end
            if (e_sack) begin b.s_req = 0; sp = 0; sg = $urandom_range(0, 3); end
            else if (!sp) begin
                if (sg > 0) sg--;
                else if ($urandom_range(0, 1) == 1) begin
                    b.s_req = 1; sp = 1; b.s_rnw = 1'($urandom);
                    b.s_a0 = 1'($urandom); b.s_wdata = 8'($urandom);
                end
            end else if (e_act && m_gs) begin
                b.s_rnw = 1'($urandom); b.s_a0 = 1'($urandom); b.s_wdata = 8'($urandom);
                if ($urandom_range(0, 7) == 0) b.s_req = 0;
            end
        end
        b.w_req = 0; b.s_req = 0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_w_write();
        test_s_read();
        test_arb();
        test_reset_mid();
        test_drop_setup();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bbus_seq.md
# bbus_seq

Sequencer and arbiter for the shared byte bus (bd, brd_n, bwr_n) that the W5300 and SL811 both sit on. It takes one request stream from the W5300 memory-window decoder and one from the SL811 port decoder, and grants one of them at a time. For each granted access it drives address, chip select, data and strobes with parameterised setup, strobe, hold and recovery timing. It sits in the CPLD top between the Z80 decode logic and the bd pins.

## Interface
Parameters:
- SETUP_W, default 1: cycles address/cs are valid before strobe, minimum 1.
- STB_W, default 2: W5300 strobe width in cycles, minimum 1.
- STB_S, default 3: SL811 strobe width in cycles, minimum 1.
- RECOV, default 2: idle cycles after each access before the next grant, minimum 0.
- CNT_W, default 4: width of the timing counter; every parameter must be at most 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- w_req  in  1  W5300 access request, level, held until w_ack.
- w_rnw  in  1  1 = read, 0 = write.
- w_addr  in  10  W5300 address.
- w_wdata  in  8  W5300 write data.
- w_ack  out  1  one-cycle completion pulse.
- w_rdata  out  8  read data, valid from w_ack onward.
- s_req, s_rnw  in  1 each  SL811 request and direction, same rules as W5300.
- s_a0  in  1  SL811 register select (0 = address, 1 = data).
- s_wdata  in  8  SL811 write data.
- s_ack  out  1  one-cycle completion pulse.
- s_rdata  out  8  read data, valid from s_ack onward.
- bd_i  in  8  bus data input.
- bd_o  out  8  bus data output.
- bd_oe  out  1  bus output enable.
- brd_n, bwr_n  out  1 each  bus strobes.
- w5300_addr  out  10  W5300 address pins.
- w5300_cs_n  out  1  W5300 chip select.
- sl811_a0  out  1  SL811 register select pin.
- sl811_cs_n  out  1  SL811 chip select.
- busy  out  1  high in every state except IDLE.

## Operation
States:
- IDLE: no access in progress.
- SETUP: address and chip select driven, strobes inactive.
- STROBE: active strobe driven.
- HOLD: strobe released, address/cs/data still held.
- RECOV: bus quiet before the next grant.

Transitions:
- IDLE → SETUP when any request is high. The grant, rnw, address/a0 and wdata are latched in that same cycle.
- SETUP lasts SETUP_W cycles, then → STROBE.
- STROBE lasts STB_W (W5300 grant) or STB_S (SL811 grant) cycles, then → HOLD.
- HOLD lasts 1 cycle, then → RECOV, or → IDLE if RECOV = 0.
- RECOV lasts RECOV cycles, then → IDLE.

Arbitration:
- Only one requester high: it is granted.
- Both high in IDLE: round-robin. A priority bit points to the winner and toggles to the other requester after every grant. Reset value of the bit selects W5300 first.
- The losing requester waits with its request held. It is granted on the first IDLE cycle after RECOV completes.

Bus outputs:
- Granted cs_n is low from SETUP through HOLD. The other chip's cs_n stays high.
- w5300_addr / sl811_a0 carry the latched values from SETUP through HOLD and hold their last value otherwise.
- brd_n is low only in STROBE when rnw = 1. bwr_n is low only in STROBE when rnw = 0. The two are never low together.
- For writes, bd_oe is high from SETUP through HOLD and bd_o = latched wdata. For reads, bd_oe stays 0.
- For reads, bd_i is captured into the granted rdata register on the last STROBE cycle. The other requester's rdata is unchanged.

Ack and request handling:
- ack pulses in the HOLD cycle, to the granted requester only.
- The requester must drop req the cycle after ack. A req still high in IDLE (RECOV = 0 case) is treated as a new access.
- If req drops mid-access, the access completes normally and ack is still pulsed.
- Input changes after the grant cycle do not affect the access in progress.

## Timing
- Reset values (async): state IDLE, all strobes and cs_n = 1, bd_oe = 0, bd_o = 0, acks = 0, rdata = 0, w5300_addr = 0, sl811_a0 = 0, busy = 0, priority = W5300.
- Reset asserted mid-access: strobes and cs deassert immediately, no ack is issued, and the access is lost.
- Grant-to-ack latency: SETUP_W + STB + 1 cycles after the IDLE grant cycle. Defaults: W5300 = 4, SL811 = 5.
- Back-to-back accesses occupy SETUP_W + STB + 1 + RECOV + 1 (IDLE) cycles each. Defaults: W5300 = 7 cycles per access.

## Test plan
- W5300 write, w_addr = 0x2AB, w_wdata = 0x5A → w5300_cs_n low for 4 cycles, bwr_n low for exactly cycles 2–3, bd_o = 0x5A with bd_oe high, w_ack in cycle 4, sl811_cs_n stays 1.
- SL811 read, s_a0 = 1, bd_i = 0xC3 → brd_n low for 3 cycles, s_rdata = 0xC3 at s_ack, sl811_a0 = 1 throughout, bd_oe = 0.
- w_req and s_req raised in the same cycle, both held for 4 accesses → grants alternate W, S, W, S, and no grant occurs during RECOV.
- Back-to-back W5300 requests with RECOV = 0 → next SETUP starts 1 cycle after HOLD and strobes never overlap.
- rst_n pulsed low during STROBE → brd_n, bwr_n and cs_n go to 1 without waiting for clk, no ack fires, and state is IDLE after release.
- s_req dropped during SETUP → access completes, s_ack pulses once, and no second access follows.
